// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: next-PC op encodings and PC-unit defaults.
package mips_pkg;

  localparam int          WIDTH_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic [3:0] {
    NPC_SEQ  = 4'd0,
    NPC_BEQ  = 4'd1,
    NPC_BNE  = 4'd2,
    NPC_BLEZ = 4'd3,
    NPC_BGTZ = 4'd4,
    NPC_BLTZ = 4'd5,
    NPC_BGEZ = 4'd6,
    NPC_J    = 4'd7,
    NPC_JR   = 4'd8
  } npc_op_e;

endpackage

// File: rtl/br_cmp.sv
// Control-transfer condition for a D-stage next-PC op; jumps are unconditional,
// unknown ops never transfer.
module br_cmp
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       npc_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             cond
);

  logic w_rs_neg;
  logic w_rs_zero;

  assign w_rs_neg  = rs_val[WIDTH-1];
  assign w_rs_zero = (rs_val == '0);

  always_comb begin
    cond = 1'b0;
    case (npc_op)
      NPC_BEQ:        cond = (rs_val == rt_val);
      NPC_BNE:        cond = (rs_val != rt_val);
      NPC_BLEZ:       cond = w_rs_neg | w_rs_zero;
      NPC_BGTZ:       cond = ~w_rs_neg & ~w_rs_zero;
      NPC_BLTZ:       cond = w_rs_neg;
      NPC_BGEZ:       cond = ~w_rs_neg;
      NPC_J, NPC_JR:  cond = 1'b1;
      default:        cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register plus D-stage control-transfer resolution, exception/eret
// redirects and a one-entry pending redirect for instruction-memory holds.
module pc_gen
  import mips_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(EXC_VEC_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_d,
  input  logic             fetch_hold,
  input  logic [3:0]       npc_op,
  input  logic [WIDTH-1:0] pc_d,
  input  logic [25:0]      instr_idx,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] npc,
  output logic             taken,
  output logic [WIDTH-1:0] link_addr,
  output logic             adel_f,
  output logic             pend_valid
);

  logic [WIDTH-1:0] r_pc_f;
  logic             r_adel;
  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pend_tgt;

  logic             w_cond;
  logic             w_taken;
  logic [WIDTH-1:0] w_off;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_j_tgt;
  logic [WIDTH-1:0] w_d_tgt;
  logic             w_redir_vld;
  logic [WIDTH-1:0] w_redir_tgt;
  logic [WIDTH-1:0] w_npc;

  br_cmp #(.WIDTH(WIDTH)) u_br_cmp (
    .npc_op (npc_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cond   (w_cond)
  );

  assign w_taken  = w_cond & ~stall_d;
  assign w_off    = {{(WIDTH-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
  assign w_br_tgt = pc_d + WIDTH'(4) + w_off;

  // The jump region bits above bit 27 only exist when WIDTH exceeds 28.
  if (WIDTH > 28) begin : g_jwide
    assign w_j_tgt = {pc_d[WIDTH-1:28], instr_idx, 2'b00};
  end else begin : g_jnarrow
    assign w_j_tgt = {instr_idx, 2'b00};
  end

  always_comb begin
    w_d_tgt = w_br_tgt;
    case (npc_op)
      NPC_J:   w_d_tgt = w_j_tgt;
      NPC_JR:  w_d_tgt = rs_val;
      default: w_d_tgt = w_br_tgt;
    endcase
  end

  // Redirects that may be captured into the pending slot (exc, eret, D transfer).
  always_comb begin
    w_redir_vld = 1'b0;
    w_redir_tgt = '0;
    if (exc_req) begin
      w_redir_vld = 1'b1;
      w_redir_tgt = EXC_VEC;
    end else if (eret) begin
      w_redir_vld = 1'b1;
      w_redir_tgt = epc;
    end else if (w_taken) begin
      w_redir_vld = 1'b1;
      w_redir_tgt = w_d_tgt;
    end
  end

  always_comb begin
    if (w_redir_vld)       w_npc = w_redir_tgt;
    else if (r_pend_valid) w_npc = r_pend_tgt;
    else if (stall_d)      w_npc = r_pc_f;
    else                   w_npc = r_pc_f + WIDTH'(4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f       <= RESET_PC;
      r_adel       <= |RESET_PC[1:0];
      r_pend_valid <= 1'b0;
      r_pend_tgt   <= '0;
    end else if (!fetch_hold) begin
      r_pc_f       <= w_npc;
      r_adel       <= |w_npc[1:0];
      r_pend_valid <= 1'b0;
    end else if (w_redir_vld) begin
      // Latest redirect wins while fetch is held.
      r_pend_valid <= 1'b1;
      r_pend_tgt   <= w_redir_tgt;
    end
  end

  assign pc_f       = r_pc_f;
  assign npc        = w_npc;
  assign taken      = w_taken;
  assign link_addr  = pc_d + WIDTH'(8);
  assign adel_f     = r_adel;
  assign pend_valid = r_pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// against a behavioural next-PC model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d, fetch_hold, exc_req, eret;
  logic [3:0]  npc_op;
  logic [31:0] pc_d, rs_val, rt_val, epc;
  logic [25:0] instr_idx;
  logic [31:0] pc_f, npc, link_addr;
  logic        taken, adel_f, pend_valid;

  int n_chk  = 0;
  int n_fail = 0;

  pc_gen dut (
    .clk        (clk),
    .reset      (reset),
    .stall_d    (stall_d),
    .fetch_hold (fetch_hold),
    .npc_op     (npc_op),
    .pc_d       (pc_d),
    .instr_idx  (instr_idx),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .pc_f       (pc_f),
    .npc        (npc),
    .taken      (taken),
    .link_addr  (link_addr),
    .adel_f     (adel_f),
    .pend_valid (pend_valid)
  );

  always #5 clk = ~clk;

  // Reference: does the D op transfer control (ignoring stall)?
  function automatic bit ref_cond(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int a, b;
    a = rs; b = rt;
    case (op)
      4'd1: return a == b;
      4'd2: return a != b;
      4'd3: return a <= 0;
      4'd4: return a > 0;
      4'd5: return a < 0;
      4'd6: return a >= 0;
      4'd7, 4'd8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_tgt(input logic [3:0] op, input logic [31:0] pcd,
                                          input logic [25:0] idx, input logic [31:0] rs);
    int off;
    logic [15:0] imm;
    if (op == 4'd7) return (pcd & 32'hF000_0000) | ({6'd0, idx} * 4);
    if (op == 4'd8) return rs;
    imm = idx[15:0];
    off = $signed(imm);
    return pcd + 32'd4 + 32'(off * 4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_d = 0; fetch_hold = 0; exc_req = 0; eret = 0;
    npc_op = 4'd0; pc_d = 32'h0; instr_idx = 26'h0;
    rs_val = 32'h0; rt_val = 32'h0; epc = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    idle();
    reset = 1'b1;
    #12;
    n_chk++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_f, 32'h3000); end
    n_chk++; if (pend_valid !== 1'b0 || adel_f !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got pend=%b adel=%b want 0 0", pend_valid, adel_f); end
    @(negedge clk);
    reset = 1'b0;
    exp = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      step();
      exp += 4;
      n_chk++; if (pc_f !== exp) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_f, exp); end
    end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL async_reset: got %h want %h", pc_f, 32'h3000); end
    reset = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    npc_op = 4'd1; pc_d = 32'h3010; instr_idx = 26'h000FFFC; rs_val = 5; rt_val = 5;
    #1;
    n_chk++; if (taken !== 1'b1 || npc !== 32'h3004) begin n_fail++; $display("FAIL beq_taken: got t=%b npc=%h want 1 3004", taken, npc); end
    n_chk++; if (link_addr !== 32'h3018) begin n_fail++; $display("FAIL link_addr: got %h want %h", link_addr, 32'h3018); end
    instr_idx = 26'h0000010;
    #1;
    n_chk++; if (npc !== 32'h3054) begin n_fail++; $display("FAIL beq_fwd: got %h want %h", npc, 32'h3054); end
    rt_val = 6;
    #1;
    n_chk++; if (taken !== 1'b0 || npc !== pc_f + 4) begin n_fail++; $display("FAIL beq_not: got t=%b npc=%h want 0 %h", taken, npc, pc_f + 4); end
    npc_op = 4'd5; rs_val = 32'h8000_0000;
    #1;
    n_chk++; if (taken !== 1'b1 || npc !== 32'h3054) begin n_fail++; $display("FAIL bltz: got t=%b npc=%h want 1 3054", taken, npc); end
    npc_op = 4'd4; rs_val = 32'h0;
    #1;
    n_chk++; if (taken !== 1'b0) begin n_fail++; $display("FAIL bgtz_zero: got %b want 0", taken); end
    npc_op = 4'd12; rs_val = 32'h1;
    #1;
    n_chk++; if (taken !== 1'b0) begin n_fail++; $display("FAIL op_unknown: got %b want 0", taken); end
  endtask

  task automatic test_jump();
    do_reset();
    npc_op = 4'd7; pc_d = 32'h3000_0100; instr_idx = 26'h0000C40;
    #1;
    n_chk++; if (taken !== 1'b1 || npc !== 32'h3000_3100) begin n_fail++; $display("FAIL j_tgt: got t=%b npc=%h want 1 30003100", taken, npc); end
    step();
    n_chk++; if (pc_f !== 32'h3000_3100) begin n_fail++; $display("FAIL j_pc: got %h want %h", pc_f, 32'h3000_3100); end
    npc_op = 4'd8; rs_val = 32'h3002;
    step();
    n_chk++; if (pc_f !== 32'h3002 || adel_f !== 1'b1) begin n_fail++; $display("FAIL jr: got pc=%h adel=%b want 3002 1", pc_f, adel_f); end
  endtask

  task automatic test_hold();
    do_reset();
    fetch_hold = 1;
    npc_op = 4'd2; pc_d = 32'h3010; instr_idx = 26'h000000B; rs_val = 1; rt_val = 2;
    #1;
    n_chk++; if (taken !== 1'b1) begin n_fail++; $display("FAIL hold_taken: got %b want 1", taken); end
    step();
    idle(); fetch_hold = 1;
    n_chk++; if (pend_valid !== 1'b1 || pc_f !== 32'h3000) begin n_fail++; $display("FAIL hold_pend: got pend=%b pc=%h want 1 3000", pend_valid, pc_f); end
    step(); step();
    n_chk++; if (pend_valid !== 1'b1 || pc_f !== 32'h3000 || npc !== 32'h3040) begin n_fail++; $display("FAIL hold_keep: got pend=%b pc=%h npc=%h want 1 3000 3040", pend_valid, pc_f, npc); end
    fetch_hold = 0;
    step();
    n_chk++; if (pend_valid !== 1'b0 || pc_f !== 32'h3040) begin n_fail++; $display("FAIL hold_release: got pend=%b pc=%h want 0 3040", pend_valid, pc_f); end
  endtask

  task automatic test_exc_eret();
    do_reset();
    exc_req = 1; eret = 1; stall_d = 1; epc = 32'h3020;
    npc_op = 4'd1; pc_d = 32'h3010; instr_idx = 26'h0000010; rs_val = 3; rt_val = 3;
    #1;
    n_chk++; if (taken !== 1'b0 || npc !== 32'h4180) begin n_fail++; $display("FAIL exc_prio: got t=%b npc=%h want 0 4180", taken, npc); end
    step();
    n_chk++; if (pc_f !== 32'h4180) begin n_fail++; $display("FAIL exc_pc: got %h want %h", pc_f, 32'h4180); end
    idle(); eret = 1; epc = 32'h3020;
    step();
    n_chk++; if (pc_f !== 32'h3020) begin n_fail++; $display("FAIL eret_pc: got %h want %h", pc_f, 32'h3020); end
  endtask

  task automatic test_stall();
    do_reset();
    stall_d = 1; npc_op = 4'd1; pc_d = 32'h3010; instr_idx = 26'h0000010; rs_val = 7; rt_val = 7;
    #1;
    n_chk++; if (taken !== 1'b0 || npc !== 32'h3000) begin n_fail++; $display("FAIL stall_comb: got t=%b npc=%h want 0 3000", taken, npc); end
    step();
    n_chk++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL stall_hold: got %h want %h", pc_f, 32'h3000); end
    stall_d = 0;
    #1;
    n_chk++; if (taken !== 1'b1) begin n_fail++; $display("FAIL stall_drop: got %b want 1", taken); end
    step();
    n_chk++; if (pc_f !== 32'h3054) begin n_fail++; $display("FAIL stall_redir: got %h want %h", pc_f, 32'h3054); end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_pend_t, r_t, e_npc;
    bit          m_pend, r_v, e_taken;
    do_reset();
    m_pc = 32'h3000; m_pend = 0; m_pend_t = 0;
    for (int i = 0; i < 300; i++) begin
      stall_d    = ($urandom_range(0, 3) == 0);
      fetch_hold = ($urandom_range(0, 3) == 0);
      exc_req    = ($urandom_range(0, 15) == 0);
      eret       = ($urandom_range(0, 15) == 0);
      npc_op     = 4'($urandom_range(0, 15));
      pc_d       = $urandom;
      instr_idx  = 26'($urandom);
      rs_val     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rt_val     = ($urandom_range(0, 1) == 0) ? rs_val : $urandom;
      epc        = $urandom;
      #1;
      e_taken = ref_cond(npc_op, rs_val, rt_val) && !stall_d;
      r_v = 1; r_t = 32'h4180;
      if (exc_req)      r_t = 32'h4180;
      else if (eret)    r_t = epc;
      else if (e_taken) r_t = ref_tgt(npc_op, pc_d, instr_idx, rs_val);
      else              r_v = 0;
      e_npc = r_v ? r_t : m_pend ? m_pend_t : stall_d ? m_pc : m_pc + 4;
      n_chk++; if (taken !== e_taken || npc !== e_npc || link_addr !== pc_d + 8) begin
        n_fail++; $display("FAIL rand_comb%0d: got t=%b npc=%h link=%h want %b %h %h", i, taken, npc, link_addr, e_taken, e_npc, pc_d + 8);
      end
      if (!fetch_hold) begin m_pc = e_npc; m_pend = 0; end
      else if (r_v) begin m_pend = 1; m_pend_t = r_t; end
      step();
      n_chk++; if (pc_f !== m_pc || pend_valid !== m_pend || adel_f !== (m_pc[1:0] != 2'b00)) begin
        n_fail++; $display("FAIL rand_reg%0d: got pc=%h pend=%b adel=%b want %h %b %b", i, pc_f, pend_valid, adel_f, m_pc, m_pend, m_pc[1:0] != 2'b00);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_hold();
    test_exc_eret();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
